// File: rtl/am_class_fetch_if.sv
// Handshake bundle between the class-HV fetcher, its single-port class-HV SRAM
// and the associative memory's class HV valid/ready input.
// master: the fetcher side. slave: the SRAM/AM side.
interface am_class_fetch_if #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned AddrWidth   = 10
);
  logic                   mem_req;
  logic [AddrWidth-1:0]   mem_addr;
  logic [HVDimension-1:0] mem_rdata;
  logic [HVDimension-1:0] class_hv;
  logic                   class_hv_valid;
  logic                   class_hv_ready;

  modport master (
    output mem_req, mem_addr, class_hv, class_hv_valid,
    input  mem_rdata, class_hv_ready
  );

  modport slave (
    input  mem_req, mem_addr, class_hv, class_hv_valid,
    output mem_rdata, class_hv_ready
  );
endinterface

// File: rtl/am_class_fetch.sv
// Class-HV fetcher feeding the associative memory stage.
// On start, streams num_class * passes class HVs from the class-HV SRAM (linear
// addresses from base) to the AM, hiding the 1-cycle SRAM latency with a
// 2-entry output buffer so one HV per cycle is sustained under full ready.
// Optional feature macro: AM_CLASS_FETCH_STALL_CNT_EN (backpressure counter on
// stall_cycles_o; tied to 0 when undefined).
module am_class_fetch #(
  parameter int unsigned HVDimension     = 512,
  parameter int unsigned DataWidth       = 8,
  parameter int unsigned AddrWidth       = 10,
  parameter int unsigned ExtCounterWidth = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic [DataWidth-1:0]       num_class_i,
  input  logic                       extend_enable_i,
  input  logic [ExtCounterWidth-1:0] extend_count_i,
  input  logic [AddrWidth-1:0]       base_addr_i,
  am_class_fetch_if.master           bus,
  output logic [31:0]                stall_cycles_o
);

  localparam int unsigned PassW = ExtCounterWidth + 1;
  localparam int unsigned TotW  = DataWidth + 6;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                       r_state, w_state_d;
  logic   [TotW-1:0]            r_total, r_req_cnt, r_beat_cnt;
  logic   [AddrWidth-1:0]       r_addr;
  logic                         r_pending;
  logic   [1:0][HVDimension-1:0] r_buf;
  logic                         r_wr_ptr, r_rd_ptr;
  logic   [1:0]                 r_count;

  logic                         w_start, w_valid, w_pop, w_push, w_req, w_done;
  logic                         w_last_req, w_last_beat;
  logic   [PassW-1:0]           w_passes;
  logic   [TotW-1:0]            w_total;
  logic   [1:0]                 w_occ;

  assign w_start = start_i && (r_state == StIdle);

  // A 0 extension count means 32 passes, matching the AM's 5-bit wrap.
  always_comb begin
    w_passes = PassW'(1);
    if (extend_enable_i) begin
      w_passes = (extend_count_i == '0) ? PassW'(1 << ExtCounterWidth) : PassW'(extend_count_i);
    end
  end

  assign w_total = TotW'(num_class_i) * TotW'(w_passes);

  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid && bus.class_hv_ready;
  assign w_push      = r_pending;
  // Slots committed after this cycle's pop: buffered + in flight.
  assign w_occ       = r_count + {1'b0, r_pending} - {1'b0, w_pop};
  assign w_last_req  = (r_req_cnt == r_total - 1'b1);
  assign w_last_beat = w_pop && (r_beat_cnt == r_total - 1'b1);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state, request issue and done pulse.
  always_comb begin
    w_state_d = r_state;
    w_req     = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_d = (w_total == '0) ? StDone : StFetch;
      end
      StFetch: begin
        if (w_occ < 2'd2) begin
          w_req = 1'b1;
          if (w_last_req) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_last_beat) w_state_d = StDone;
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Config latch, address/request/beat counters and read-outstanding flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_total    <= '0;
      r_req_cnt  <= '0;
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_start) begin
        r_total    <= w_total;
        r_req_cnt  <= '0;
        r_beat_cnt <= '0;
        r_addr     <= base_addr_i;
      end else begin
        if (w_req) begin
          r_addr    <= r_addr + 1'b1;
          r_req_cnt <= r_req_cnt + 1'b1;
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      r_pending <= w_req;
    end
  end

  // 2-entry output FIFO; read data is captured in the cycle it is valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.mem_rdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.mem_req        = w_req;
  assign bus.mem_addr       = r_addr;
  assign bus.class_hv       = r_buf[r_rd_ptr];
  assign bus.class_hv_valid = w_valid;
  assign busy_o             = (r_state != StIdle);
  assign done_o             = w_done;

`ifdef AM_CLASS_FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of valid-but-not-ready cycles, cleared on start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !bus.class_hv_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_am_class_fetch.sv
// Scoreboard bench for am_class_fetch: expected addresses and class HVs are
// queued from the beat-order rule when a run starts; monitors compare them
// against the SRAM request port and the class HV handshake.
module tb_am_class_fetch;
  localparam int unsigned HVD = 512;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned ECW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           busy, done;
  logic [DW-1:0]  num_class = '0;
  logic           ee = 1'b0;
  logic [ECW-1:0] ec = '0;
  logic [AW-1:0]  base = '0;
  logic [31:0]    stall;

  am_class_fetch_if #(.HVDimension(HVD), .AddrWidth(AW)) bus_if ();

  am_class_fetch #(
    .HVDimension(HVD), .DataWidth(DW), .AddrWidth(AW), .ExtCounterWidth(ECW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .num_class_i(num_class), .extend_enable_i(ee), .extend_count_i(ec),
    .base_addr_i(base), .bus(bus_if), .stall_cycles_o(stall)
  );

  always #5 clk = ~clk;

  logic [HVD-1:0] mem [1 << AW];
  logic [AW-1:0]  exp_addr_q [$];
  logic [HVD-1:0] exp_data_q [$];
  int             n_checks = 0;
  int             n_pass   = 0;
  int             n_beats  = 0;
  int             model_stall = 0;
  int             ready_mode  = 0;
  bit             held = 1'b0;
  logic [HVD-1:0] held_data;

  task automatic chk(input string name, input logic [HVD-1:0] act, input logic [HVD-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: got an unexpected event, expected none", name);
  endtask

  // SRAM model: data valid exactly one cycle after the request.
  always @(posedge clk) begin
    if (bus_if.mem_req) bus_if.mem_rdata <= mem[bus_if.mem_addr];
    else                bus_if.mem_rdata <= {16{$urandom}};
  end

  // Ready driver: 0 always high, 1 toggling, 2 random, other always low.
  initial begin
    bus_if.class_hv_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus_if.class_hv_ready = 1'b1;
        1:       bus_if.class_hv_ready = ~bus_if.class_hv_ready;
        2:       bus_if.class_hv_ready = 1'($urandom_range(0, 1));
        default: bus_if.class_hv_ready = 1'b0;
      endcase
    end
  end

  // Request monitor.
  initial forever begin
    @(negedge clk);
    if (!rst && bus_if.mem_req) begin
      if (exp_addr_q.size() == 0) flag("extra_req");
      else chk("mem_addr", bus_if.mem_addr, exp_addr_q.pop_front());
    end
  end

  // Beat monitor: ordering, stability under backpressure, stall count.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("valid_held", bus_if.class_hv_valid, 1'b1);
        chk("data_stable", bus_if.class_hv, held_data);
      end
      if (bus_if.class_hv_valid && bus_if.class_hv_ready) begin
        n_beats++;
        if (exp_data_q.size() == 0) flag("extra_beat");
        else chk("beat_data", bus_if.class_hv, exp_data_q.pop_front());
      end
      if (bus_if.class_hv_valid && !bus_if.class_hv_ready) model_stall++;
      held      = bus_if.class_hv_valid && !bus_if.class_hv_ready;
      held_data = bus_if.class_hv;
    end
  end

  task automatic load_expect(input int nc, input bit e, input int c, input int b);
    int passes, total;
    logic [AW-1:0] a;
    passes = e ? ((c == 0) ? 32 : c) : 1;
    total  = nc * passes;
    exp_addr_q.delete();
    exp_data_q.delete();
    // Beat k: pass k/nc, class k%nc, laid out pass-major from base.
    for (int k = 0; k < total; k++) begin
      a = AW'(b + (k / nc) * nc + (k % nc));
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
  endtask

  task automatic run(input int nc, input bit e, input int c, input int b, input int mode,
                     input bit check_lat, input bit second_start);
    int passes, total, lat, budget;
    passes = e ? ((c == 0) ? 32 : c) : 1;
    total  = nc * passes;
    budget = 4 * total + 40;
    load_expect(nc, e, c, b);
    n_beats     = 0;
    model_stall = 0;
    ready_mode  = mode;
    @(negedge clk);
    num_class = DW'(nc);
    ee        = e;
    ec        = ECW'(c);
    base      = AW'(b);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    num_class = DW'($urandom);
    ee        = 1'($urandom);
    ec        = ECW'($urandom);
    base      = AW'($urandom);
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (second_start && k == 3) start = 1'b1;
      if (second_start && k == 4) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      flag("done_timeout");
      return;
    end
    chk("busy_at_done", busy, 1'b1);
    if (check_lat) chk("done_latency", lat, (total == 0) ? 1 : total + 3);
    chk("beat_count", n_beats, total);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("data_q_empty", exp_data_q.size(), 0);
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
    chk("done_single", done, 1'b0);
    chk("valid_idle", bus_if.class_hv_valid, 1'b0);
`ifdef AM_CLASS_FETCH_STALL_CNT_EN
    chk("stall_cycles", stall, model_stall);
`else
    chk("stall_cycles", stall, 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mem_req"}, bus_if.mem_req, 1'b0);
    chk({tag, "_mem_addr"}, bus_if.mem_addr, 0);
    chk({tag, "_valid"}, bus_if.class_hv_valid, 1'b0);
    chk({tag, "_class_hv"}, bus_if.class_hv, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      for (int j = 0; j < 16; j++) mem[i][j*32 +: 32] = $urandom;
      mem[i][AW-1:0] = AW'(i);
    end

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(4, 1'b0, 0, 'h010, 0, 1'b1, 1'b0);
    run(3, 1'b1, 2, int'($urandom_range(0, 1000)), 1, 1'b0, 1'b0);
    run(0, 1'b0, 0, 'h123, 0, 1'b1, 1'b0);
    run(1, 1'b1, 0, 'h200, 0, 1'b1, 1'b0);
    run(2, 1'b1, 2, (1 << AW) - 2, 0, 1'b1, 1'b1);

    // Reset with one read in flight, then a clean run.
    load_expect(8, 1'b0, 0, 'h040);
    ready_mode = 3;
    @(negedge clk);
    num_class = 8'd8;
    ee        = 1'b0;
    base      = 'h040;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run(5, 1'b1, 1, 'h300, 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run($urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          int'($urandom_range(0, (1 << AW) - 1)), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
